// File: rtl/param_cpu.sv
// Parameterised register-file CPU; call stack enabled by defining PARAM_CPU_STACK_EN.
// Latency: one instruction per Go edge; Dval pulses the cycle after any write to R[NREG-2].
// Backpressure: none; Go low freezes all state except Sample latching into R[NREG-4].
module param_cpu #(
    parameter int DW     = 8,
    parameter int NREG   = 32,
    parameter int AW     = 8,
    parameter int SDEPTH = 4,
    localparam int RA    = $clog2(NREG),
    localparam int IW    = 4 + 3 + 2 + DW + 2 + DW + AW
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          Go,
    input  logic [IW-1:0] Instr,
    input  logic [DW-1:0] Din,
    input  logic          Sample,
    output logic [AW-1:0] IP,
    output logic [DW-1:0] Dout,
    output logic          Dval,
    output logic [DW-1:0] GPO,
    output logic [DW-1:0] Flags
);
    localparam int SHFT = 0;
    localparam int OFLW = 1;

    if (DW < 4 || NREG < 8 || (NREG & (NREG - 1)) != 0 || SDEPTH < 1) begin : g_param_chk
        $error("param_cpu: illegal parameter set");
    end

    logic [AW-1:0] ip;
    logic [DW-1:0] regs [NREG];
    logic          dval;

    logic [3:0]    grp;
    logic [2:0]    cmd;
    logic [1:0]    t1, t2;
    logic [DW-1:0] a1, a2;
    logic [AW-1:0] addr;

    assign grp  = Instr[IW-1 -: 4];
    assign cmd  = Instr[IW-5 -: 3];
    assign t1   = Instr[IW-8 -: 2];
    assign a1   = Instr[IW-10 -: DW];
    assign t2   = Instr[AW+DW +: 2];
    assign a2   = Instr[AW +: DW];
    assign addr = Instr[AW-1:0];

    // Operand decode: direct index p, indirect index q, resolved location l and value v.
    logic [RA-1:0] p1, q1, l1, p2, q2, l2;
    logic [DW-1:0] v1, v2;

    assign p1 = RA'(a1);
    assign q1 = RA'(regs[p1]);
    assign l1 = (t1 == 2'd1) ? p1 : (t1 == 2'd2) ? q1 : '0;
    assign v1 = (t1 == 2'd1) ? regs[p1] : (t1 == 2'd2) ? regs[q1] : a1;
    assign p2 = RA'(a2);
    assign q2 = RA'(regs[p2]);
    assign l2 = (t2 == 2'd1) ? p2 : (t2 == 2'd2) ? q2 : '0;
    assign v2 = (t2 == 2'd1) ? regs[p2] : (t2 == 2'd2) ? regs[q2] : a2;

    logic [DW-1:0]   opd;
    logic [2*DW-1:0] ua, ub, sa, sb, sum_u, sum_s, mul_u, mul_s;

    assign opd   = regs[l1];
    assign ua    = {{DW{1'b0}}, opd};
    assign ub    = {{DW{1'b0}}, v2};
    assign sa    = {{DW{opd[DW-1]}}, opd};
    assign sb    = {{DW{v2[DW-1]}}, v2};
    assign sum_u = ua + ub;
    assign sum_s = sa + sb;
    assign mul_u = ua * ub;
    assign mul_s = sa * sb;

    logic eq, ltu, lts, take;
    assign eq  = (v1 == v2);
    assign ltu = (v1 < v2);
    assign lts = ($signed(v1) < $signed(v2));

    always_comb begin
        case (cmd)
            3'd0:    take = 1'b1;
            3'd1:    take = eq;
            3'd2:    take = ltu;
            3'd3:    take = lts;
            3'd4:    take = ltu | eq;
            3'd5:    take = lts | eq;
            default: take = 1'b0;
        endcase
    end

`ifdef PARAM_CPU_STACK_EN
    localparam int SPW    = $clog2(SDEPTH + 1);
    localparam int SIW    = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam int STKERR = 2;
    logic [AW-1:0]  stack [SDEPTH];
    logic [SPW-1:0] sp;
    logic           push, pop;
`endif

    logic [AW-1:0] nxt_ip;
    logic [DW-1:0] nxt_flags;
    logic          wr_en;
    logic [RA-1:0] wr_idx;
    logic [DW-1:0] wr_dat;

    always_comb begin
        nxt_ip    = ip + AW'(1);
        nxt_flags = regs[NREG-1];
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_dat    = '0;
`ifdef PARAM_CPU_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        case (grp)
            4'd0: begin
                wr_en  = 1'b1;
                wr_idx = l2;
                case (cmd)
                    3'd1: begin
                        wr_dat          = {v1[DW-2:0], 1'b0};
                        nxt_flags[SHFT] = v1[DW-1];
                    end
                    3'd2: begin
                        wr_dat          = {1'b0, v1[DW-1:1]};
                        nxt_flags[SHFT] = v1[0];
                    end
                    default: wr_dat = v1;
                endcase
            end
            4'd1: begin
                wr_en  = (cmd != 3'd7);
                wr_idx = l1;
                case (cmd)
                    3'd0: begin
                        wr_dat          = sum_u[DW-1:0];
                        nxt_flags[OFLW] = |sum_u[2*DW-1:DW];
                    end
                    3'd1: begin
                        wr_dat          = sum_s[DW-1:0];
                        nxt_flags[OFLW] = (sum_s[2*DW-1:DW] != {DW{sum_s[DW-1]}});
                    end
                    3'd2: begin
                        wr_dat          = mul_u[DW-1:0];
                        nxt_flags[OFLW] = |mul_u[2*DW-1:DW];
                    end
                    3'd3: begin
                        wr_dat          = mul_s[DW-1:0];
                        nxt_flags[OFLW] = (mul_s[2*DW-1:DW] != {DW{mul_s[DW-1]}});
                    end
                    3'd4:    wr_dat = opd & v2;
                    3'd5:    wr_dat = opd | v2;
                    3'd6:    wr_dat = opd ^ v2;
                    default: wr_dat = '0;
                endcase
            end
            4'd2: if (take) nxt_ip = addr;
            4'd3: begin
                if (int'(cmd) < DW && regs[NREG-1][cmd]) begin
                    nxt_ip         = addr;
                    nxt_flags[cmd] = 1'b0;
                end
            end
`ifdef PARAM_CPU_STACK_EN
            4'd4: begin
                if (cmd == 3'd0) begin
                    if (sp == SPW'(SDEPTH)) nxt_flags[STKERR] = 1'b1;
                    else begin
                        push   = 1'b1;
                        nxt_ip = addr;
                    end
                end else if (cmd == 3'd1) begin
                    if (sp == '0) nxt_flags[STKERR] = 1'b1;
                    else begin
                        pop    = 1'b1;
                        nxt_ip = stack[SIW'(sp - SPW'(1))];
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Later assignments win: Sample, then flag side-effects, then the explicit register write.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ip   <= '0;
            dval <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
`ifdef PARAM_CPU_STACK_EN
            sp <= '0;
            for (int i = 0; i < SDEPTH; i++) stack[i] <= '0;
`endif
        end else begin
            dval <= Go && wr_en && (wr_idx == RA'(NREG - 2));
            if (Sample) regs[NREG-4] <= Din;
            if (Go) begin
                ip           <= nxt_ip;
                regs[NREG-1] <= nxt_flags;
                if (wr_en) regs[wr_idx] <= wr_dat;
`ifdef PARAM_CPU_STACK_EN
                if (push) begin
                    stack[SIW'(sp)] <= ip + AW'(1);
                    sp              <= sp + SPW'(1);
                end else if (pop) begin
                    sp <= sp - SPW'(1);
                end
`endif
            end
        end
    end

    assign IP    = ip;
    assign Dout  = regs[NREG-2];
    assign Dval  = dval;
    assign GPO   = regs[NREG-3];
    assign Flags = regs[NREG-1];
endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DW, default 8: data and register width in bits, minimum 4.
REQ-002 Parameter NREG, default 32: register count, power of two, minimum 8; RA = log2(NREG).
REQ-003 Parameter AW, default 8: instruction-pointer width; instruction width IW = 4+3+2+DW+2+DW+AW.
REQ-004 Parameter SDEPTH, default 4: call-stack depth, minimum 1.
REQ-005 Clock  input  1: single clock; all state updates on the rising edge.
REQ-006 nReset  input  1: reset, asynchronous, active-low.
REQ-007 Go  input  1: when high on a rising edge, execute one instruction.
REQ-008 Instr  input  IW: instruction at IP from external async program memory.
REQ-009 Din  input  DW: external data in.
REQ-010 Sample  input  1: when high, latch Din into register NREG-4.
REQ-011 IP  output  AW: current instruction pointer.
REQ-012 Dout  output  DW: register NREG-2.
REQ-013 Dval  output  1: one-cycle pulse after any write to register NREG-2.
REQ-014 GPO  output  DW: register NREG-3.
REQ-015 Flags  output  DW: register NREG-1; bit0 SHFT, bit1 OFLW, bit2 STKERR.

Function
REQ-016 Fields, MSB first: grp[3:0], cmd[2:0], t1[1:0], a1[DW], t2[1:0], a2[DW], addr[AW].
REQ-017 Argument type: 0 immediate; 1 register a[RA-1:0]; 2 indirect Reg[Reg[a][RA-1:0]]; 3 immediate. Destination for type 0/3 is register 0.
REQ-018 Instruction completes in the Go cycle; IP <= IP+1 (wraps modulo 2^AW) unless stated otherwise.
REQ-019 grp 0 MOV: src = arg1, dest = loc(arg2); cmd 1 SHL sets SHFT = src[DW-1] and writes src<<1; cmd 2 SHR sets SHFT = src[0] and writes src>>1; other cmd values copy.
REQ-020 grp 1 ACC: R = loc(arg1), v = arg2; cmd 0 unsigned add, 1 signed add, 2 unsigned mul, 3 signed mul, 4 AND, 5 OR, 6 XOR; R <= result[DW-1:0].
REQ-021 Add/mul use a full 2*DW-bit result; OFLW set if unsigned > 2^DW-1 or signed outside [-2^(DW-1), 2^(DW-1)-1], else cleared; logic ops leave OFLW unchanged.
REQ-022 grp 2 JMP: compare arg1,arg2; cmd 0 always, 1 EQ, 2 unsigned LT, 3 signed LT, 4 unsigned LE, 5 signed LE, 6-7 never; if true IP <= addr.
REQ-023 grp 3 ATC: if Flags[cmd] set, IP <= addr; Flags[cmd] <= 0 in the same cycle.
REQ-024 grp 4 STK: cmd 0 CALL pushes IP+1 and IP <= addr; cmd 1 RET pops into IP; other cmd values NOP.
REQ-025 CALL with SDEPTH entries held: no push, IP <= IP+1, STKERR <= 1; RET on empty stack: IP <= IP+1, STKERR <= 1.
REQ-026 grp 5-15: NOP.
REQ-027 Flag side-effects apply first; an explicit instruction write to register NREG-1 in the same cycle overrides all flag bits.
REQ-028 Sample and an instruction write to NREG-4 in the same cycle: instruction write wins.
REQ-029 Go low: no state change except Sample latching; Dval stays low.

Reset
REQ-030 nReset low asynchronously clears IP, all registers, stack pointer and Dval, even mid-instruction.
REQ-031 After nReset deasserts, the first Go executes the instruction at address 0.

Configuration
REQ-032 PARAM_CPU_STACK_EN defined: stack and grp 4 implemented per REQ-024/025.
REQ-033 PARAM_CPU_STACK_EN undefined: no stack storage; grp 4 is NOP; STKERR is never set by hardware.

Verification
REQ-034 DW=8: MOV imm 0x81 to R3 with SHL -> R3=0x02, SHFT=1, IP=1.
REQ-035 ACC signed add R1=0x7F plus imm 1 -> R1=0x80, OFLW=1; unsigned mul 16*16 -> 0x00, OFLW=1.
REQ-036 JMP signed LT 0xFF vs 0x01 with addr 0x20 -> IP=0x20; unsigned LT with same operands -> IP=IP+1.
REQ-037 SDEPTH=4: five nested CALLs -> fifth not taken, STKERR=1; four RETs restore IPs in LIFO order; fifth RET sets STKERR.
REQ-038 MOV imm 0x55 to R30 -> Dout=0x55, Dval high exactly one cycle; nReset low mid-run -> IP=0, Dout=0, Dval=0 without a clock edge.
